// File: rtl/hash_pkg.sv
// Shared types, constants and helpers for the hash round controller.
package hash_pkg;

  localparam int unsigned H_WIDTH = 8;
  localparam int unsigned NUM_H   = 8;
  localparam int unsigned IDX_W   = 3;

  typedef logic [H_WIDTH-1:0]   h_word_t;
  typedef h_word_t [NUM_H-1:0]  h_state_t;

  typedef struct packed {
    h_word_t data;
    logic    last;
  } msg_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT,
    ROUND,
    DONE
  } state_t;

  localparam h_word_t C [NUM_H] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                     8'h55, 8'h66, 8'h77, 8'h88};

  // Rotate left by r[2:0]; the upper half of {x,x}<<r is the rotated word.
  function automatic h_word_t rotl8(input h_word_t x, input int unsigned r);
    logic [2*H_WIDTH-1:0] d;
    d = {x, x} << r[2:0];
    return d[2*H_WIDTH-1 -: H_WIDTH];
  endfunction

endpackage

// File: rtl/hash_round_ctrl_if.sv
// Message byte valid/ready handshake into the round controller.
interface hash_round_ctrl_if;
  import hash_pkg::*;

  logic    msg_valid;
  logic    msg_ready;
  h_word_t msg_byte;
  logic    msg_last;

  modport master (output msg_valid, output msg_byte, output msg_last, input msg_ready);
  modport slave  (input msg_valid, input msg_byte, input msg_last, output msg_ready);
endinterface

// File: rtl/hash_round_fn.sv
// Combinational round function: rotl((h ^ m) + C[idx], ROT), sum mod 256.
module hash_round_fn
  import hash_pkg::*;
#(
  parameter int unsigned ROT = 3
) (
  input  h_word_t          h,
  input  h_word_t          m,
  input  logic [IDX_W-1:0] idx,
  output h_word_t          h_new
);

  h_word_t sum;

  always_comb begin
    sum   = (h ^ m) + C[idx];
    h_new = rotl8(sum, ROT);
  end

endmodule

// File: rtl/hash_round_ctrl.sv
// Sequences H init and per-byte round updates for hash_registers.
module hash_round_ctrl
  import hash_pkg::*;
#(
  parameter int unsigned ROT        = 3,
  parameter int unsigned NUM_PASSES = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  hash_round_ctrl_if.slave   msg,
  input  h_state_t           H_in,
  output logic               init_H,
  output logic               update_H,
  output logic [IDX_W-1:0]   i_count,
  output h_word_t            H_update,
  output logic               busy,
  output logic               done
);

  localparam int unsigned         PASS_W    = 2;
  localparam logic [PASS_W-1:0]   LAST_PASS = PASS_W'(NUM_PASSES - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_H - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  i_nxt;
  logic [PASS_W-1:0] pass, pass_nxt;
  msg_t              msg_q, msg_nxt;
  logic              init_nxt, update_nxt, ready_nxt, busy_nxt, done_nxt;

  // Next state plus Moore outputs decoded from the next state, then registered.
  always_comb begin
    state_nxt = state;
    i_nxt     = i_count;
    pass_nxt  = pass;
    msg_nxt   = msg_q;

    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = WAIT;
      WAIT: begin
        if (msg.msg_valid) begin
          msg_nxt   = '{data: msg.msg_byte, last: msg.msg_last};
          i_nxt     = '0;
          pass_nxt  = '0;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        i_nxt = i_count + IDX_W'(1);
        if (i_count == LAST_IDX) begin
          if (pass != LAST_PASS) pass_nxt  = pass + PASS_W'(1);
          else                   state_nxt = msg_q.last ? DONE : WAIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    init_nxt   = (state_nxt == INIT);
    update_nxt = (state_nxt == ROUND);
    ready_nxt  = (state_nxt == WAIT);
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      i_count       <= '0;
      pass          <= '0;
      msg_q         <= '0;
      init_H        <= 1'b0;
      update_H      <= 1'b0;
      msg.msg_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      i_count       <= i_nxt;
      pass          <= pass_nxt;
      msg_q         <= msg_nxt;
      init_H        <= init_nxt;
      update_H      <= update_nxt;
      msg.msg_ready <= ready_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  // H_in[i] is read here before the edge that writes it back, so no hazard.
  hash_round_fn #(.ROT(ROT)) u_round (
    .h     (H_in[i_count]),
    .m     (msg_q.data),
    .idx   (i_count),
    .h_new (H_update)
  );

endmodule
